mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single-port shared_memory between N_REQ requesters (the per-core cache controllers).
- Accepts one line request at a time, issues it to memory and waits for read data.
- Routes each read response back to the requester that issued it.
- Keeps at most one memory transaction in flight, which matches the memory's single-outstanding-read rule.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 64, request address width
- DATA_WIDTH, 512, line data width (64-byte line)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- up_req_valid  in  N_REQ  per-requester request valid
- up_req_write  in  N_REQ  per-requester 1=write, 0=read
- up_req_addr  in  N_REQ*ADDR_WIDTH  packed addresses; slice i belongs to requester i
- up_req_wdata  in  N_REQ*DATA_WIDTH  packed write data
- up_req_ready  out  N_REQ  one-hot accept strobe
- up_resp_valid  out  N_REQ  one-hot read-response pulse
- up_resp_rdata  out  DATA_WIDTH  read data, shared by all requesters, qualified by up_resp_valid
- up_wr_done  out  N_REQ  one-hot write-complete pulse
- mem_req_valid  out  1  to memory
- mem_req_write  out  1  to memory
- mem_req_addr  out  ADDR_WIDTH  to memory
- mem_req_wdata  out  DATA_WIDTH  to memory
- mem_req_ready  in  1  from memory
- mem_resp_valid  in  1  from memory
- mem_resp_rdata  in  DATA_WIDTH  from memory
- err_unexp_resp  out  1  sticky: mem_resp_valid arrived while not in WAIT_RD

Behaviour:
- Reset: single clock, synchronous active-low reset on rst_n.
  - State=IDLE, rr_ptr=0, all holding registers zeroed.
  - Every registered output is 0: mem_req_*, up_resp_*, up_wr_done, err_unexp_resp.
  - up_req_ready is 0 while rst_n=0.
  - Reset mid-transaction abandons it; no response is delivered afterwards.
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - The winner is the first i with up_req_valid[i]=1, searching from rr_ptr upward modulo N_REQ.
  - up_req_ready is asserted combinationally for the winner only, in the same cycle. The handshake completes in that cycle.
  - The arbiter latches write/addr/wdata/owner into holding registers.
  - rr_ptr becomes (winner+1) mod N_REQ, and the state goes to ISSUE.
  - If no request is valid, the arbiter stays in IDLE and up_req_ready=0.
- ISSUE:
  - mem_req_valid=1, with mem_req_* driven from the holding registers and held stable until mem_req_ready=1.
  - On acceptance of a write: pulse up_wr_done[owner] next cycle, go to IDLE.
  - On acceptance of a read: go to WAIT_RD.
  - mem_req_valid drops the cycle after acceptance.
- WAIT_RD:
  - On mem_resp_valid, register the data into up_resp_rdata and pulse up_resp_valid[owner] one cycle later; go to IDLE.
  - up_resp_rdata holds its value until the next read response.
- Latency:
  - Request accepted at cycle t puts mem_req_valid=1 at t+1.
  - A write sees up_wr_done at (memory accept)+1.
  - A read sees up_resp_valid at (mem_resp_valid)+1.
- Throughput:
  - At most one transaction in flight.
  - A new grant can occur in the first IDLE cycle after a return, so there is no dead cycle beyond the FSM path.
- Fairness: a continuously requesting requester waits at most N_REQ-1 transactions.
- Simultaneous events: up_req_valid is ignored outside IDLE. A requester holds valid, unchanged, until it sees up_req_ready.
- Spurious response: mem_resp_valid outside WAIT_RD is dropped and sets err_unexp_resp, which clears only on reset.
- Address and data pass through unmodified; the memory does line-offset masking.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, adds outputs grant_cnt (N_REQ*32) and max_wait_cnt (N_REQ*16).
  - grant_cnt: per-requester 32-bit count of grants.
  - max_wait_cnt: per-requester 16-bit high-water mark of cycles spent with valid=1 before ready. Its running counter saturates at 0xFFFF.
  - Both reset to 0, and the counters wrap.
- When undefined, these ports and the logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - the FSM state enum (arb_state_e: IDLE, ISSUE, WAIT_RD);
  - the holding-register struct (write, addr, wdata, owner index of width $clog2(N_REQ));
  - the default width constants.
- Sub-module rr_arbiter (parameter N) takes req[N] and ptr, and outputs a one-hot grant plus the winner index. It is purely combinational and unit-tested separately.

Test Plan:
- Single read: req 2 reads addr 0x1C0 holding 0xA5 pattern; memory latency 4 -> mem_req at t+1, up_resp_valid[2] only, rdata=pattern, up_resp_valid[0,1,3]=0.
- All four valid at once, all writes of data=i to addr 0x40*i, rr_ptr=0 -> grant order 0,1,2,3, one up_wr_done per requester in that order; readback of each address returns i.
- Continuous requests from 1 and 3 -> grants alternate 1,3,1,3; no requester waits more than 3 transactions.
- Memory holds mem_req_ready=0 for 10 cycles -> mem_req_* stable throughout; no up_req_ready asserted during ISSUE.
- Spurious mem_resp_valid pulse in IDLE -> err_unexp_resp=1, no up_resp_valid, and the next normal read still completes.
- rst_n=0 for one cycle during WAIT_RD -> all outputs 0, state IDLE, late mem_resp_valid sets err_unexp_resp and is not routed.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter.
// Holding-register fields are sized for the largest supported configuration.
package mem_arb_pkg;

    localparam int N_REQ_DEF      = 4;
    localparam int ADDR_WIDTH_DEF = 64;
    localparam int DATA_WIDTH_DEF = 512;
    localparam int OWNER_W_MAX    = 3;  // enough to index up to 8 requesters

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD
    } arb_state_e;

    typedef struct packed {
        logic                      write;
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [DATA_WIDTH_DEF-1:0] wdata;
        logic [OWNER_W_MAX-1:0]    owner;
    } hold_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted req at or above ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; grant is all-zero when no request is asserted.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [N-1:0] rot;
    logic [IW:0]  sum;

    always_comb begin
        rot = N'({req, req} >> ptr);
        sum = '0;
        // Descending scan leaves the lowest set bit of the rotated vector.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = (IW + 1)'(k);
            end
        end
        sum = sum + {1'b0, ptr};
        if (sum >= (IW + 1)'(N)) begin
            sum = sum - (IW + 1)'(N);
        end
        idx        = sum[IW-1:0];
        grant      = '0;
        grant[idx] = |req;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sequencer sharing a single-port memory; one transaction in flight.
// Latency: grant at t -> mem_req_valid at t+1; wr_done / resp_valid one cycle after memory accept / response.
// Backpressure: mem_req_* held until mem_req_ready; no grants outside IDLE. Optional MEM_ARB_PERF_CNT_EN adds counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            up_req_valid,
    input  logic [N_REQ-1:0]            up_req_write,
    input  logic [N_REQ*ADDR_WIDTH-1:0] up_req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] up_req_wdata,
    output logic [N_REQ-1:0]            up_req_ready,
    output logic [N_REQ-1:0]            up_resp_valid,
    output logic [DATA_WIDTH-1:0]       up_resp_rdata,
    output logic [N_REQ-1:0]            up_wr_done,
    output logic                        mem_req_valid,
    output logic                        mem_req_write,
    output logic [ADDR_WIDTH-1:0]       mem_req_addr,
    output logic [DATA_WIDTH-1:0]       mem_req_wdata,
    input  logic                        mem_req_ready,
    input  logic                        mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]       mem_resp_rdata,
    output logic                        err_unexp_resp
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [N_REQ*32-1:0]         grant_cnt,
    output logic [N_REQ*16-1:0]         max_wait_cnt
`endif
);

    localparam int IW = $clog2(N_REQ);

    arb_state_e       state, state_d;
    logic [IW-1:0]    rr_ptr, ptr_next, win_idx;
    logic [N_REQ-1:0] win_oh, owner_oh, wr_done_q, resp_valid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic             err_q, grant_now;
    hold_t            hold_q, hold_d;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req   (up_req_valid),
        .ptr   (rr_ptr),
        .grant (win_oh),
        .idx   (win_idx)
    );

    assign grant_now    = rst_n && (state == IDLE) && (|up_req_valid);
    assign up_req_ready = grant_now ? win_oh : '0;
    assign ptr_next     = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign owner_oh     = N_REQ'(1) << hold_q.owner;

    // Mux the winner's request fields into the holding register image.
    always_comb begin
        hold_d       = '0;
        hold_d.owner = OWNER_W_MAX'(win_idx);
        for (int i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) begin
                hold_d.write = up_req_write[i];
                hold_d.addr  = ADDR_WIDTH_DEF'(up_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
                hold_d.wdata = DATA_WIDTH_DEF'(up_req_wdata[i*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (|up_req_valid)  state_d = ISSUE;
            ISSUE:   if (mem_req_ready)  state_d = hold_q.write ? IDLE : WAIT_RD;
            WAIT_RD: if (mem_resp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            hold_q       <= '0;
            wr_done_q    <= '0;
            resp_valid_q <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state        <= state_d;
            wr_done_q    <= '0;
            resp_valid_q <= '0;
            if (grant_now) begin
                hold_q <= hold_d;
                rr_ptr <= ptr_next;
            end
            if (state == ISSUE && mem_req_ready && hold_q.write) begin
                wr_done_q <= owner_oh;
            end
            if (state == WAIT_RD && mem_resp_valid) begin
                resp_valid_q <= owner_oh;
                rdata_q      <= mem_resp_rdata;
            end
            // Responses outside WAIT_RD have no owner and are dropped.
            if (mem_resp_valid && state != WAIT_RD) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mem_req_valid  = (state == ISSUE);
    assign mem_req_write  = hold_q.write;
    assign mem_req_addr   = hold_q.addr[ADDR_WIDTH-1:0];
    assign mem_req_wdata  = hold_q.wdata[DATA_WIDTH-1:0];
    assign up_wr_done     = wr_done_q;
    assign up_resp_valid  = resp_valid_q;
    assign up_resp_rdata  = rdata_q;
    assign err_unexp_resp = err_q;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] gcnt     [N_REQ];
    logic [15:0] wait_run [N_REQ];
    logic [15:0] wait_max [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_perf
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                gcnt[g]     <= '0;
                wait_run[g] <= '0;
                wait_max[g] <= '0;
            end else if (up_req_ready[g]) begin
                gcnt[g]     <= gcnt[g] + 32'd1;
                wait_run[g] <= '0;
                if (wait_run[g] > wait_max[g]) begin
                    wait_max[g] <= wait_run[g];
                end
            end else if (up_req_valid[g] && wait_run[g] != 16'hFFFF) begin
                wait_run[g] <= wait_run[g] + 16'd1;
            end
        end
        assign grant_cnt[g*32 +: 32]    = gcnt[g];
        assign max_wait_cnt[g*16 +: 16] = wait_max[g];
    end
`endif

endmodule
